// File: rtl/ex_flag_stage_pkg.sv
// Shared opcode, condition-code and FSM definitions for the EX->MEM flag stage.
// Optional FLAG_BYPASS_EN lets branches see next-cycle flags.
package ex_flag_stage_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PADDSB = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b0011;
    localparam logic [3:0] OP_NOR    = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_DRAIN  = 2'd1;
    localparam state_t ST_HALTED = 2'd2;

    function automatic logic sets_nzv(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic sets_z(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_NOR) ||
               (op == OP_SLL) || (op == OP_SRL) ||
               (op == OP_SRA);
    endfunction

endpackage

// File: rtl/ex_flag_stage_if.sv
// EX-side instruction bundle presented by the arithmetic unit.
// Master drives the bundle, slave is the flag stage.
interface ex_flag_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          ex_valid;
    logic [3:0]    ex_op;
    logic [DW-1:0] ex_result;
    logic          ex_v;
    logic          ex_n;
    logic [RW-1:0] ex_dst;
    logic          ex_we;

    modport master (
        output ex_valid, ex_op, ex_result,
        output ex_v, ex_n, ex_dst, ex_we
    );

    modport slave (
        input ex_valid, ex_op, ex_result,
        input ex_v, ex_n, ex_dst, ex_we
    );
endinterface

// File: rtl/ex_flag_stage_branch_cond_eval.sv
// Combinational branch condition evaluator on N/Z/V flags.
// Shared with the hazard unit.
module branch_cond_eval
    import ex_flag_stage_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (ccc)
            CC_NE:     taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GTE:    taken = z | ~n;
            CC_LTE:    taken = n | z;
            CC_OVFL:   taken = v;
            CC_UNCOND: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// EX->MEM register, N/Z/V flag register, branch evaluation and HLT drain FSM.
// FLAG_BYPASS_EN: branch uses the flags being written this cycle.
module ex_flag_stage
    import ex_flag_stage_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic                clk,
    input  logic                rst,
    ex_flag_stage_if.slave      ex,
    input  logic                stall,
    input  logic                flush,
    input  logic [2:0]          br_ccc,
    output logic                br_taken,
    output logic                mem_valid,
    output logic [DW-1:0]       mem_result,
    output logic [RW-1:0]       mem_dst,
    output logic                mem_we,
    output logic                flag_z,
    output logic                flag_n,
    output logic                flag_v,
    output logic                halted
);

    state_t state;
    logic   acc;
    logic   is_hlt;
    logic   nxt_z;
    logic   nxt_n;
    logic   nxt_v;

    assign acc = ex.ex_valid & ~stall & ~flush
               & (state == ST_RUN);
    assign is_hlt = (ex.ex_op == OP_HLT);
    assign halted = (state == ST_HALTED);

    // Z always derived from the full result, not the AU.
    always_comb begin
        nxt_z = flag_z;
        nxt_n = flag_n;
        nxt_v = flag_v;
        if (acc && sets_nzv(ex.ex_op)) begin
            nxt_z = (ex.ex_result == '0);
            nxt_n = ex.ex_n;
            nxt_v = ex.ex_v;
        end else if (acc && sets_z(ex.ex_op)) begin
            nxt_z = (ex.ex_result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_result <= '0;
            mem_dst    <= '0;
        end else if (acc) begin
            mem_valid  <= 1'b1;
            mem_we     <= ex.ex_we & ~is_hlt;
            mem_result <= ex.ex_result;
            mem_dst    <= ex.ex_dst;
        end else if (!stall) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            flag_z <= nxt_z;
            flag_n <= nxt_n;
            flag_v <= nxt_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            unique case (state)
                ST_RUN:
                    if (acc && is_hlt) state <= ST_DRAIN;
                ST_DRAIN:
                    if (!stall) state <= ST_HALTED;
                default:
                    state <= ST_HALTED;
            endcase
        end
    end

    branch_cond_eval u_bce (
        .ccc   (br_ccc),
`ifdef FLAG_BYPASS_EN
        .z     (nxt_z),
        .n     (nxt_n),
        .v     (nxt_v),
`else
        .z     (flag_z),
        .n     (flag_n),
        .v     (flag_v),
`endif
        .taken (br_taken)
    );

endmodule
